crc7_frame_ctrl: RTL

Frame-level controller for the CRC-7 checking path: takes a bit-serial frame (DATA_BITS payload bits then 7 CRC bits, MSB first) and runs the CRC-7 LFSR (x^7+x^3+1, init 0) over the payload. It then compares the received CRC bits against the computed value and reports a one-cycle verdict. An inactivity watchdog aborts a stalled frame. Sits between the serial receive front end and the frame consumer.

---
 rtl/crc7_pkg.sv | 22 ++
 rtl/crc7_lfsr.sv | 28 ++
 rtl/crc7_frame_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/crc7_pkg.sv
// Shared CRC-7 definitions (x^7 + x^3 + 1, init 0) for the checker and the future encoder.
package crc7_pkg;

  localparam int         CRC7_WIDTH = 7;
  localparam logic [6:0] CRC7_POLY  = 7'h09;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One serial step of the MSB-first LFSR.
  function automatic logic [CRC7_WIDTH-1:0] crc7_step(input logic [CRC7_WIDTH-1:0] crc,
                                                      input logic                  b);
    logic fb;
    fb = b ^ crc[CRC7_WIDTH-1];
    return {crc[CRC7_WIDTH-2:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/crc7_lfsr.sv
// Bit-serial CRC-7 LFSR; clr and shift in the same cycle shift the bit into a cleared register.
module crc7_lfsr
  import crc7_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  shift,
  input  logic                  bit_in,
  output logic [CRC7_WIDTH-1:0] crc
);

  logic [CRC7_WIDTH-1:0] r_crc;
  logic [CRC7_WIDTH-1:0] w_base;

  assign w_base = clr ? '0 : r_crc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_crc <= '0;
    end else if (clr || shift) begin
      r_crc <= shift ? crc7_step(w_base, bit_in) : w_base;
    end
  end

  assign crc = r_crc;

endmodule

// File: rtl/crc7_frame_ctrl.sv
// Frame controller: runs CRC-7 over a serial payload, checks the trailing 7 CRC bits,
// reports a one-cycle verdict and aborts stalled frames with a watchdog.
module crc7_frame_ctrl
  import crc7_pkg::*;
#(
  parameter int DATA_BITS = 40,
  parameter int TIMEOUT   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  output logic                  busy,
  output logic [CRC7_WIDTH-1:0] crc_out,
  output logic                  done,
  output logic                  crc_ok,
  output logic                  crc_err,
  output logic                  timeout_err
);

  // The bit counter also indexes the 7 CRC bits, so it is never narrower than 3 bits.
  localparam int BIT_CNT_W  = ($clog2(DATA_BITS + 1) < 3) ? 3 : $clog2(DATA_BITS + 1);
  localparam int IDLE_CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [BIT_CNT_W-1:0]  LAST_DATA  = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [BIT_CNT_W-1:0]  LAST_CHECK = BIT_CNT_W'(CRC7_WIDTH - 1);
  localparam logic [IDLE_CNT_W-1:0] IDLE_LIMIT = IDLE_CNT_W'(TIMEOUT - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic [BIT_CNT_W-1:0]  w_bit_cnt_next;
  logic [IDLE_CNT_W-1:0] r_idle_cnt;
  logic [IDLE_CNT_W-1:0] w_idle_cnt_next;
  logic                  r_mismatch;
  logic                  w_mismatch_next;
  logic [CRC7_WIDTH-1:0] r_crc_out;
  logic [CRC7_WIDTH-1:0] w_crc_out_next;
  logic                  r_busy, r_done, r_crc_ok, r_crc_err, r_timeout_err;
  logic                  w_busy_next, w_done_next, w_crc_ok_next, w_crc_err_next;
  logic                  w_timeout_err_next;

  logic [CRC7_WIDTH-1:0] w_crc;
  logic [CRC7_WIDTH-1:0] w_crc_final;
  logic [BIT_CNT_W-1:0]  w_cnt_base;
  logic [2:0]            w_check_idx;
  logic                  w_active, w_accept, w_data_phase;
  logic                  w_last_data, w_last_check, w_bit_mis, w_timeout;

  // frame_start restarts from any state and may carry payload bit 0 in the same cycle.
  assign w_active     = (r_state == DATA) || (r_state == CHECK);
  assign w_accept     = bit_valid && (frame_start || w_active);
  assign w_data_phase = frame_start || (r_state == DATA);
  assign w_cnt_base   = frame_start ? '0 : r_bit_cnt;
  assign w_last_data  = w_accept && w_data_phase && (w_cnt_base == LAST_DATA);
  assign w_check_idx  = 3'(CRC7_WIDTH - 1) - r_bit_cnt[2:0];
  assign w_bit_mis    = w_accept && !w_data_phase && (bit_in != r_crc_out[w_check_idx]);
  assign w_last_check = w_accept && !w_data_phase && (r_bit_cnt == LAST_CHECK);
  assign w_timeout    = w_active && !frame_start && !bit_valid && (r_idle_cnt == IDLE_LIMIT);
  assign w_crc_final  = crc7_step(frame_start ? '0 : w_crc, bit_in);

  crc7_lfsr u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .clr    (frame_start),
    .shift  (w_accept && w_data_phase),
    .bit_in (bit_in),
    .crc    (w_crc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_bit_cnt     <= '0;
      r_idle_cnt    <= '0;
      r_mismatch    <= 1'b0;
      r_crc_out     <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_crc_ok      <= 1'b0;
      r_crc_err     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_bit_cnt     <= w_bit_cnt_next;
      r_idle_cnt    <= w_idle_cnt_next;
      r_mismatch    <= w_mismatch_next;
      r_crc_out     <= w_crc_out_next;
      r_busy        <= w_busy_next;
      r_done        <= w_done_next;
      r_crc_ok      <= w_crc_ok_next;
      r_crc_err     <= w_crc_err_next;
      r_timeout_err <= w_timeout_err_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (frame_start) begin
      w_state_next = w_last_data ? CHECK : DATA;
    end else begin
      case (r_state)
        IDLE:    w_state_next = IDLE;
        DATA:    if (w_timeout) w_state_next = IDLE;
                 else if (w_last_data) w_state_next = CHECK;
        CHECK:   if (w_timeout) w_state_next = IDLE;
                 else if (w_last_check) w_state_next = DONE;
        DONE:    w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    w_bit_cnt_next = w_cnt_base;
    if (!frame_start && !w_active) w_bit_cnt_next = '0;
    if (w_accept) w_bit_cnt_next = (w_last_data || w_last_check) ? '0 : w_cnt_base + 1'b1;
    if (w_timeout) w_bit_cnt_next = '0;

    w_idle_cnt_next = '0;
    if (w_active && !frame_start && !bit_valid && !w_timeout) w_idle_cnt_next = r_idle_cnt + 1'b1;

    w_mismatch_next = frame_start ? 1'b0 : (r_mismatch | w_bit_mis);
    w_crc_out_next  = w_last_data ? w_crc_final : r_crc_out;

    w_busy_next        = (w_state_next == DATA) || (w_state_next == CHECK);
    w_done_next        = w_last_check;
    w_crc_ok_next      = w_last_check && !(r_mismatch || w_bit_mis);
    w_crc_err_next     = w_last_check && (r_mismatch || w_bit_mis);
    w_timeout_err_next = w_timeout;
  end

  assign busy        = r_busy;
  assign crc_out     = r_crc_out;
  assign done        = r_done;
  assign crc_ok      = r_crc_ok;
  assign crc_err     = r_crc_err;
  assign timeout_err = r_timeout_err;

endmodule
